// File: rtl/gate_response_checker_pkg.sv
// gate_response_checker_pkg: shared FSM states and reference truth tables for 2-input gate checks
package gate_response_checker_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
endpackage

// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if: sample stream from the gate under test and the checker's verdict
interface gate_response_checker_if #(parameter int CNT_W = 8) ();
   logic             start;
   logic             in_valid;
   logic             in_a;
   logic             in_b;
   logic             in_y;
   logic             busy;
   logic             done;
   logic             pass;
   logic             timeout;
   logic [3:0]       observed_tt;
   logic [3:0]       seen;
   logic [CNT_W-1:0] mismatch_cnt;
   modport master (
      output start, in_valid, in_a, in_b, in_y,
      input  busy, done, pass, timeout, observed_tt, seen, mismatch_cnt
   );
   modport slave (
      input  start, in_valid, in_a, in_b, in_y,
      output busy, done, pass, timeout, observed_tt, seen, mismatch_cnt
   );
endinterface

// File: rtl/gate_response_checker_sat_counter.sv
// gate_response_checker_sat_counter: up counter that sticks at all-ones, with synchronous clear
module gate_response_checker_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   // clear wins over increment; increment stops once every bit is set
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: rebuilds a 2-input gate truth table from samples and grades it
module gate_response_checker
   import gate_response_checker_pkg::*;
#(
   parameter logic [3:0] EXPECTED_TT = TT_AND,
   parameter int         TIMEOUT     = 255,
   parameter int         CNT_W       = 8
) (
   input logic                    clk,
   input logic                    rst,
   gate_response_checker_if.slave bus
);
   state_t           state, state_nx;
   logic [3:0]       seen, observed_tt, seen_nx, observed_nx;
   logic [1:0]       idx;
   logic [CNT_W-1:0] cyc_cnt;
   logic             conflict, conflict_nx, pass, timeout;
   logic             take, hit, complete, expire;

   assign idx         = {bus.in_a, bus.in_b};
   assign take        = state == COLLECT && bus.in_valid && !bus.start;
   assign hit         = take && !seen[idx];
   assign seen_nx     = hit ? seen | (4'b0001 << idx) : seen;
   assign observed_nx = hit ? observed_tt | ({3'b000, bus.in_y} << idx) : observed_tt;
   assign conflict_nx = conflict | (take && seen[idx] && bus.in_y != observed_tt[idx]);
   assign complete    = state == COLLECT && !bus.start && seen_nx == 4'hF;
   assign expire      = state == COLLECT && !bus.start && !complete && cyc_cnt == CNT_W'(TIMEOUT - 1);

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;

   // start restarts from any state; collection ends on a full table or on expiry
   always_comb
      state_nx = bus.start ? COLLECT : (complete || expire) ? REPORT : state;

   // table capture, conflict tracking and the verdict latched on leaving COLLECT
   always_ff @(posedge clk or posedge rst)
      if (rst || bus.start) begin
         seen        <= '0;
         observed_tt <= '0;
         conflict    <= 1'b0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
         cyc_cnt     <= '0;
      end else if (state == COLLECT) begin
         seen        <= seen_nx;
         observed_tt <= observed_nx;
         conflict    <= conflict_nx;
         cyc_cnt     <= cyc_cnt + 1'b1;
         pass        <= complete && observed_nx == EXPECTED_TT && !conflict_nx;
         timeout     <= expire;
      end

   gate_response_checker_sat_counter #(.CNT_W(CNT_W)) u_mismatch (
      .clk (clk),
      .rst (rst),
      .clr (bus.start),
      .inc (take && bus.in_y != EXPECTED_TT[idx]),
      .cnt (bus.mismatch_cnt)
   );

   assign bus.busy        = state == COLLECT;
   assign bus.done        = state == REPORT;
   assign bus.pass        = pass;
   assign bus.timeout     = timeout;
   assign bus.observed_tt = observed_tt;
   assign bus.seen        = seen;
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: directed and random sample streams graded against a truth-table model
module tb_gate_response_checker;
   import gate_response_checker_pkg::*;
   localparam logic [3:0] EXP = TT_AND;
   localparam int         TMO = 255;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gate_response_checker_if #(.CNT_W(8)) bus ();
   gate_response_checker #(.EXPECTED_TT(EXP), .TIMEOUT(TMO), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   bit       m_col, m_rep, m_conf, m_pass, m_to;
   bit [3:0] m_seen, m_obs;
   int       m_mis, m_n;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, o, e);
      end
   endtask

   function automatic logic [19:0] outs();
      return {bus.busy, bus.done, bus.pass, bus.timeout, bus.observed_tt, bus.seen, bus.mismatch_cnt};
   endfunction

   function automatic logic [19:0] model_vec();
      return {m_col, m_rep, m_pass, m_to, m_obs, m_seen, 8'(m_mis)};
   endfunction

   task automatic model_clear();
      {m_col, m_rep, m_conf, m_pass, m_to} = '0;
      m_seen = '0;
      m_obs  = '0;
      m_mis  = 0;
      m_n    = 0;
   endtask

   task automatic cycle(input bit st, input bit v, input bit a, input bit b, input bit y);
      int i;
      @(negedge clk);
      bus.start = st; bus.in_valid = v; bus.in_a = a; bus.in_b = b; bus.in_y = y;
      @(posedge clk);
      i = 2 * a + b;
      if (st) begin
         model_clear();
         m_col = 1'b1;
      end else if (m_col) begin
         m_n++;
         if (v) begin
            if (!m_seen[i]) begin
               m_seen[i] = 1'b1;
               m_obs[i]  = y;
            end else if (m_obs[i] != y) m_conf = 1'b1;
            if (y != EXP[i]) m_mis = m_mis < 255 ? m_mis + 1 : 255;
         end
         if (m_seen == 4'hF) begin
            m_col  = 1'b0;
            m_rep  = 1'b1;
            m_pass = m_obs == EXP && !m_conf;
         end else if (m_n == TMO) begin
            m_col = 1'b0;
            m_rep = 1'b1;
            m_to  = 1'b1;
         end
      end
      #1;
      chk("model", outs(), model_vec());
      bus.start = 1'b0; bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic samp(input bit a, input bit b, input bit y);
      cycle(1'b0, 1'b1, a, b, y);
   endtask

   task automatic spaced(input bit [3:0] ys);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         idle(19);
         samp(k[1], k[0], ys[k]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit a, b, y, st;
      int i;
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_a = 1'b0; bus.in_b = 1'b0; bus.in_y = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("reset_outs", outs(), 20'h0);
      rst = 1'b0;
      idle(2);
      samp(1'b1, 1'b1, 1'b1);
      chk("idle_ignores_sample", outs(), 20'h0);

      spaced(4'b1000);
      chk("happy_done", bus.done, 1'b1);
      chk("happy_pass", bus.pass, 1'b1);
      chk("happy_obs", bus.observed_tt, 4'b1000);
      chk("happy_mis", bus.mismatch_cnt, 8'd0);
      chk("happy_timeout", bus.timeout, 1'b0);
      samp(1'b0, 1'b0, 1'b1);
      chk("report_ignores_sample", bus.mismatch_cnt, 8'd0);

      spaced(4'b1010);
      chk("faulty_obs", bus.observed_tt, 4'b1010);
      chk("faulty_pass", bus.pass, 1'b0);
      chk("faulty_mis", bus.mismatch_cnt, 8'd1);

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      samp(1'b0, 1'b0, 1'b0);
      samp(1'b0, 1'b0, 1'b1);
      samp(1'b0, 1'b1, 1'b0);
      samp(1'b1, 1'b0, 1'b0);
      samp(1'b1, 1'b1, 1'b1);
      chk("conflict_done", bus.done, 1'b1);
      chk("conflict_pass", bus.pass, 1'b0);
      chk("conflict_obs", bus.observed_tt, 4'b1000);
      chk("conflict_mis", bus.mismatch_cnt, 8'd1);

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      samp(1'b0, 1'b0, 1'b0);
      samp(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 300 && !bus.done; k++) idle(1);
      chk("timeout_done", bus.done, 1'b1);
      chk("timeout_flag", bus.timeout, 1'b1);
      chk("timeout_pass", bus.pass, 1'b0);
      chk("timeout_seen", bus.seen, 4'b1001);

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      samp(1'b0, 1'b0, 1'b0);
      samp(1'b0, 1'b1, 1'b0);
      samp(1'b1, 1'b0, 1'b0);
      idle(TMO - 4);
      chk("edge_still_busy", bus.busy, 1'b1);
      samp(1'b1, 1'b1, 1'b1);
      chk("edge_done", bus.done, 1'b1);
      chk("edge_timeout", bus.timeout, 1'b0);
      chk("edge_pass", bus.pass, 1'b1);

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (300) samp(1'b0, 1'b0, 1'b1);
      chk("sat_mis", bus.mismatch_cnt, 8'd255);
      chk("sat_timeout", bus.timeout, 1'b1);

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      samp(1'b0, 1'b0, 1'b1);
      samp(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("restart_seen", bus.seen, 4'b0000);
      chk("restart_busy", bus.busy, 1'b1);
      chk("restart_mis", bus.mismatch_cnt, 8'd0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("start_sample_seen", bus.seen, 4'b0000);
      chk("start_sample_mis", bus.mismatch_cnt, 8'd0);
      samp(1'b1, 1'b1, 1'b0);
      chk("after_start_seen", bus.seen, 4'b1000);
      chk("after_start_mis", bus.mismatch_cnt, 8'd1);

      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_clear();
      chk("async_rst", outs(), 20'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      for (int r = 0; r < 20; r++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < 60; k++) begin
            a  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            i  = 2 * a + b;
            y  = EXP[i] ^ ($urandom_range(0, 5) == 0);
            st = $urandom_range(0, 59) == 0;
            cycle(st, 1'($urandom_range(0, 1)), a, b, y);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
